// File: rtl/inst_encoder.sv
// Encodes decoded operation descriptors back into 32-bit MIPS instruction words.
// One registered output word; the LI32 pseudo-op stages its second word in a pending register.
module inst_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [3:0]  in_aluop,
    input  logic        in_u,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [31:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        err
);

    typedef enum logic [3:0] {
        K_R_ALU = 4'd0, K_I_ALU = 4'd1, K_LW  = 4'd2, K_SW  = 4'd3, K_BEQ  = 4'd4,
        K_BNE   = 4'd5, K_J     = 4'd6, K_JAL = 4'd7, K_JR  = 4'd8, K_LI32 = 4'd9
    } kind_e;

    typedef enum logic [3:0] {
        A_ADD  = 4'h0, A_SUB  = 4'h1, A_SLT  = 4'h2, A_SLTU = 4'h3,
        A_AND  = 4'h4, A_OR   = 4'h5, A_XOR  = 4'h6, A_NOR  = 4'h7,
        A_SLL  = 4'h8, A_SRL  = 4'h9, A_SRA  = 4'ha, A_SLLV = 4'hb,
        A_SRLV = 4'hc, A_SRAV = 4'hd, A_LUI  = 4'he, A_DFT  = 4'hf
    } aluop_e;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q,  out_inst_d;
    logic        out_last_q,  out_last_d;
    logic        err_q,       err_d;
    logic        pend_q,      pend_d;
    logic [31:0] pend_inst_q, pend_inst_d;

    logic        enc_err, enc_two;
    logic [31:0] enc_word, enc_second;
    logic [5:0]  op, func;
    logic [4:0]  rs, shamt;
    logic        accept;

    assign in_ready = !pend_q && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Pure field encoder for the descriptor currently on the input.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves a latch.
        enc_err    = 1'b0;
        enc_two    = 1'b0;
        enc_word   = '0;
        enc_second = '0;
        op         = '0;
        func       = '0;
        rs         = in_rs;
        shamt      = '0;
        case (in_kind)
            K_R_ALU: begin
                case (in_aluop)
                    A_ADD:  func = in_u ? 6'h21 : 6'h20;
                    A_SUB:  func = in_u ? 6'h23 : 6'h22;
                    A_SLT:  func = 6'h2a;
                    A_SLTU: func = 6'h2b;
                    A_AND:  func = 6'h24;
                    A_OR:   func = 6'h25;
                    A_XOR:  func = 6'h26;
                    A_NOR:  func = 6'h27;
                    A_SLL:  begin func = 6'h00; rs = '0; shamt = in_shamt; end
                    A_SRL:  begin func = 6'h02; rs = '0; shamt = in_shamt; end
                    A_SRA:  begin func = 6'h03; rs = '0; shamt = in_shamt; end
                    A_SLLV: func = 6'h04;
                    A_SRLV: func = 6'h06;
                    A_SRAV: func = 6'h07;
                    default: enc_err = 1'b1;
                endcase
                enc_word = {6'h00, rs, in_rt, in_rd, shamt, func};
            end
            K_I_ALU: begin
                case (in_aluop)
                    A_ADD:  op = in_u ? 6'h09 : 6'h08;
                    A_SLT:  op = 6'h0a;
                    A_SLTU: op = 6'h0b;
                    A_AND:  op = 6'h0c;
                    A_OR:   op = 6'h0d;
                    A_XOR:  op = 6'h0e;
                    A_LUI:  begin op = 6'h0f; rs = '0; end
                    default: enc_err = 1'b1;
                endcase
                enc_word = {op, rs, in_rt, in_imm[15:0]};
            end
            K_LW:  enc_word = {6'h23, in_rs, in_rt, in_imm[15:0]};
            K_SW:  enc_word = {6'h2b, in_rs, in_rt, in_imm[15:0]};
            K_BEQ: enc_word = {6'h04, in_rs, in_rt, in_imm[15:0]};
            K_BNE: enc_word = {6'h05, in_rs, in_rt, in_imm[15:0]};
            K_J:   enc_word = {6'h02, in_target};
            K_JAL: enc_word = {6'h03, in_target};
            K_JR:  enc_word = {6'h00, in_rs, 15'd0, 6'h08};
            K_LI32: begin
                // A zero upper half needs only ORI from $0; otherwise LUI then ORI into rt.
                if (in_imm[31:16] != 16'd0) begin
                    enc_two    = 1'b1;
                    enc_word   = {6'h0f, 5'd0, in_rt, in_imm[31:16]};
                    enc_second = {6'h0d, in_rt, in_rt, in_imm[15:0]};
                end else begin
                    enc_word   = {6'h0d, 5'd0, in_rt, in_imm[15:0]};
                end
            end
            default: enc_err = 1'b1;
        endcase
    end

    // Output register / pending-word next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_last_d  = out_last_q;
        pend_d      = pend_q;
        pend_inst_d = pend_inst_q;
        err_d       = accept && enc_err;
        if (pend_q && out_ready) begin
            out_valid_d = 1'b1;
            out_inst_d  = pend_inst_q;
            out_last_d  = 1'b1;
            pend_d      = 1'b0;
        end else if (accept && !enc_err) begin
            out_valid_d = 1'b1;
            out_inst_d  = enc_word;
            out_last_d  = !enc_two;
            pend_d      = enc_two;
            pend_inst_d = enc_second;
        end else if (accept || out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
        if (rst) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_inst_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            pend_inst_q <= pend_inst_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vector table, hand-written corner
// sequences, and randomized streams scored against an ISA-level reference model.
module tb_inst_encoder;

    typedef struct {
        logic [3:0]  kind;
        logic [3:0]  aluop;
        logic        u;
        logic [4:0]  rs, rt, rd, shamt;
        logic [31:0] imm;
        logic [25:0] target;
    } desc_t;

    typedef struct {
        desc_t       d;
        logic [31:0] inst;
        logic        last;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_u, out_valid, out_ready, out_last, err;
    logic [3:0]  in_kind, in_aluop;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [31:0] in_imm, out_inst;
    logic [25:0] in_target;

    int tests = 0;
    int fails = 0;

    // Reference tables straight from the ISA: -1 marks an aluop with no encoding.
    int r_func[16] = '{32, 34, 42, 43, 36, 37, 38, 39, 0, 2, 3, 4, 6, 7, -1, -1};
    int i_op[16]   = '{8, -1, 10, 11, 12, 13, 14, -1, -1, -1, -1, -1, -1, -1, 15, -1};
    int legal_i[7] = '{0, 2, 3, 4, 5, 6, 14};

    logic [32:0] exp_q[$];

    inst_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_aluop(in_aluop), .in_u(in_u),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic desc_t mk(input int k, input int a, input int u, input int rs, input int rt,
                                 input int rd, input int sh, input logic [31:0] imm,
                                 input logic [25:0] tg);
        desc_t d;
        d.kind = 4'(k); d.aluop = 4'(a); d.u = 1'(u);
        d.rs = 5'(rs); d.rt = 5'(rt); d.rd = 5'(rd); d.shamt = 5'(sh);
        d.imm = imm; d.target = tg;
        return d;
    endfunction

    task automatic drive(input desc_t d);
        in_kind = d.kind; in_aluop = d.aluop; in_u = d.u;
        in_rs = d.rs; in_rt = d.rt; in_rd = d.rd; in_shamt = d.shamt;
        in_imm = d.imm; in_target = d.target;
    endtask

    // Words a descriptor should produce, computed with plain field arithmetic.
    function automatic void model(input desc_t d, output int n, output logic [31:0] w0,
                                  output logic [31:0] w1, output bit e);
        int f, op, rs, sh, hi, lo;
        n = 1; w0 = 0; w1 = 0; e = 0;
        rs = int'(d.rs);
        hi = int'(d.imm[31:16]);
        lo = int'(d.imm[15:0]);
        case (int'(d.kind))
            0: begin
                f = r_func[d.aluop];
                if (f < 0) e = 1;
                if (d.u && d.aluop <= 1) f = f + 1;
                sh = 0;
                if (d.aluop >= 8 && d.aluop <= 10) begin rs = 0; sh = int'(d.shamt); end
                w0 = 32'((rs << 21) + (int'(d.rt) << 16) + (int'(d.rd) << 11) + (sh << 6) + f);
            end
            1: begin
                op = i_op[d.aluop];
                if (op < 0) e = 1;
                if (d.u && d.aluop == 0) op = 9;
                if (d.aluop == 14) rs = 0;
                w0 = 32'(op) << 26 | 32'(rs << 21) | 32'(int'(d.rt) << 16) | 32'(lo);
            end
            2, 3, 4, 5: begin
                op = (d.kind == 2) ? 35 : (d.kind == 3) ? 43 : int'(d.kind);
                w0 = 32'(op) << 26 | 32'(rs << 21) | 32'(int'(d.rt) << 16) | 32'(lo);
            end
            6, 7: w0 = 32'(int'(d.kind) - 4) << 26 | 32'(d.target);
            8:    w0 = 32'(rs << 21) | 32'd8;
            9: begin
                if (hi != 0) begin
                    n  = 2;
                    w0 = 32'(15) << 26 | 32'(int'(d.rt) << 16) | 32'(hi);
                    w1 = 32'(13) << 26 | 32'(int'(d.rt) << 21) | 32'(int'(d.rt) << 16) | 32'(lo);
                end else begin
                    w0 = 32'(13) << 26 | 32'(int'(d.rt) << 16) | 32'(lo);
                end
            end
            default: e = 1;
        endcase
        if (e) n = 0;
    endfunction

    function automatic desc_t rand_desc(input bit mixed);
        desc_t d;
        d = mk(0, 0, 0, 0, 0, 0, 0, $urandom, 26'($urandom));
        d.u = 1'($urandom); d.rs = 5'($urandom); d.rt = 5'($urandom);
        d.rd = 5'($urandom); d.shamt = 5'($urandom);
        if (mixed) begin
            d.kind  = 4'($urandom);
            d.aluop = 4'($urandom);
            if ($urandom_range(0, 1) == 0) d.imm[31:16] = '0;
        end else begin
            d.kind  = 4'($urandom_range(0, 8));
            d.aluop = (d.kind == 1) ? 4'(legal_i[$urandom_range(0, 6)]) : 4'($urandom_range(0, 13));
        end
        return d;
    endfunction

    // Streams descriptors; every accepted one is scored through the model queue.
    task automatic run_stream(input int ncyc, input bit mixed);
        bit          exp_err = 0;
        bit          stalled = 0;
        logic [31:0] held = '0;
        logic [32:0] ent;
        logic [31:0] w0, w1;
        int          n;
        bit          e;
        for (int c = 0; c < ncyc + 4; c++) begin
            step();
            if (c < ncyc) begin
                drive(rand_desc(mixed));
                in_valid  = mixed ? ($urandom_range(0, 3) != 0) : 1'b1;
                out_ready = mixed ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            check("err_pulse", 32'(err), 32'(exp_err));
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_inst", out_inst, held);
            end
            if (!mixed && c >= 1 && c <= ncyc) check("stream_valid", 32'(out_valid), 32'd1);
            if (!mixed && c < ncyc) check("stream_ready", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", out_inst, 32'hxxxxxxxx);
                end else begin
                    ent = exp_q.pop_front();
                    check("sb_inst", out_inst, ent[31:0]);
                    check("sb_last", 32'(out_last), 32'(ent[32]));
                end
            end
            stalled = out_valid && !out_ready;
            held    = out_inst;
            exp_err = 0;
            if (in_valid && in_ready) begin
                model('{in_kind, in_aluop, in_u, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target},
                      n, w0, w1, e);
                exp_err = e;
                if (n == 1) exp_q.push_back({1'b1, w0});
                if (n == 2) begin
                    exp_q.push_back({1'b0, w0});
                    exp_q.push_back({1'b1, w1});
                end
            end
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_inst", out_inst, 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Directed single-word and error vectors with hand-derived encodings.
        vecs.push_back('{mk(0, 0, 0, 1, 2, 3, 0, 0, 0),           32'h00221820, 1'b1, 1'b0});
        vecs.push_back('{mk(0, 1, 1, 5, 6, 7, 9, 0, 0),           32'h00A63823, 1'b1, 1'b0});
        vecs.push_back('{mk(0, 8, 0, 9, 4, 2, 3, 0, 0),           32'h000410C0, 1'b1, 1'b0});
        vecs.push_back('{mk(0, 13, 0, 1, 2, 3, 5, 0, 0),          32'h00221807, 1'b1, 1'b0});
        vecs.push_back('{mk(1, 2, 0, 4, 5, 0, 0, 32'hFFFF, 0),    32'h2885FFFF, 1'b1, 1'b0});
        vecs.push_back('{mk(1, 0, 1, 1, 2, 0, 0, 32'h12348000, 0), 32'h24228000, 1'b1, 1'b0});
        vecs.push_back('{mk(1, 14, 0, 7, 3, 0, 0, 32'hABCD, 0),   32'h3C03ABCD, 1'b1, 1'b0});
        vecs.push_back('{mk(2, 5, 1, 29, 8, 0, 0, 32'h0010, 0),   32'h8FA80010, 1'b1, 1'b0});
        vecs.push_back('{mk(3, 0, 0, 29, 9, 0, 0, 32'hFFFC, 0),   32'hAFA9FFFC, 1'b1, 1'b0});
        vecs.push_back('{mk(4, 0, 0, 1, 2, 0, 0, 32'hFFFE, 0),    32'h1022FFFE, 1'b1, 1'b0});
        vecs.push_back('{mk(5, 0, 0, 3, 0, 0, 0, 32'h0005, 0),    32'h14600005, 1'b1, 1'b0});
        vecs.push_back('{mk(6, 0, 0, 0, 0, 0, 0, 0, 26'h10),      32'h08000010, 1'b1, 1'b0});
        vecs.push_back('{mk(7, 0, 0, 0, 0, 0, 0, 0, 26'h3FFFFFF), 32'h0FFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{mk(8, 0, 0, 31, 5, 6, 7, 0, 0),          32'h03E00008, 1'b1, 1'b0});
        vecs.push_back('{mk(9, 0, 0, 0, 8, 0, 0, 32'h00005678, 0), 32'h34085678, 1'b1, 1'b0});
        vecs.push_back('{mk(1, 10, 0, 4, 5, 0, 0, 32'hFFFF, 0),   32'h0, 1'b0, 1'b1});
        vecs.push_back('{mk(1, 1, 0, 4, 5, 0, 0, 32'h1, 0),       32'h0, 1'b0, 1'b1});
        vecs.push_back('{mk(0, 15, 0, 1, 2, 3, 0, 0, 0),          32'h0, 1'b0, 1'b1});
        vecs.push_back('{mk(12, 0, 0, 1, 2, 3, 0, 0, 0),          32'h0, 1'b0, 1'b1});

        foreach (vecs[i]) begin
            step();
            drive(vecs[i].d); in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(!vecs[i].err));
            if (!vecs[i].err) begin
                check($sformatf("vec%0d_inst", i), out_inst, vecs[i].inst);
                check($sformatf("vec%0d_last", i), 32'(out_last), 32'(vecs[i].last));
            end
            step();
            @(negedge clk);
            check($sformatf("vec%0d_err_off", i), 32'(err), 32'd0);
            check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // LI32 with a non-zero upper half: LUI then ORI on consecutive cycles.
        step();
        drive(mk(9, 0, 0, 0, 8, 0, 0, 32'h12345678, 0)); in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("li32_w0_inst", out_inst, 32'h3C081234);
        check("li32_w0_last", 32'(out_last), 32'd0);
        check("li32_w0_ready", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        check("li32_w1_valid", 32'(out_valid), 32'd1);
        check("li32_w1_inst", out_inst, 32'h35085678);
        check("li32_w1_last", 32'(out_last), 32'd1);
        check("li32_w1_ready", 32'(in_ready), 32'd1);
        step();
        @(negedge clk);
        check("li32_done", 32'(out_valid), 32'd0);

        // Backpressure on J with JR queued behind it; release must swap words with no bubble.
        step();
        drive(mk(6, 0, 0, 0, 0, 0, 0, 0, 26'h10)); in_valid = 1'b1; out_ready = 1'b0;
        step();
        drive(mk(8, 0, 0, 31, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_inst", out_inst, 32'h08000010);
            check("bp_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_jr_valid", 32'(out_valid), 32'd1);
        check("bp_jr_inst", out_inst, 32'h03E00008);
        check("bp_jr_last", 32'(out_last), 32'd1);
        step();

        // Reset while the LUI half is held: the ORI half must never appear.
        drive(mk(9, 0, 0, 0, 8, 0, 0, 32'h12345678, 0)); in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_li_held", out_inst, 32'h3C081234);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("rst_li_valid", 32'(out_valid), 32'd0);
        check("rst_li_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            check("rst_li_no_ori", 32'(out_valid), 32'd0);
        end

        run_stream(16, 1'b0);
        run_stream(300, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
